// File: rtl/bmem_line_arbiter.sv
// bmem_line_arbiter: shares one 64-bit burst memory port between the I-cache and
// D-cache. Whole-line requests are granted round-robin, one transaction at a time;
// read beats are gathered into a line buffer and dirty lines are sent as four beats.
module bmem_line_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [ADDR_W-1:0] d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int unsigned NBEAT   = LINE_W / BEAT_W;
    localparam int unsigned BEAT_CW = $clog2(NBEAT);
    // Clears the byte-within-line offset bits.
    localparam logic [ADDR_W-1:0]  LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(NBEAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrBurst,
        StResp
    } state_e;

    state_e              state_q;
    logic [BEAT_CW-1:0]  beat_q;
    logic                last_d_q;   // side granted by the previous transaction, 1 = D
    logic                grant_d_q;  // side owning the current transaction, 1 = D
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   line_buf_q;

    logic                i_req;
    logic                d_req;
    logic                pick_d;
    logic                beat_match;
    logic [ADDR_W-1:0]   req_addr;

    assign i_req      = i_dfp_read;
    assign d_req      = d_dfp_write | d_dfp_read;
    // On a tie the side that was not granted last time wins.
    assign pick_d     = d_req & (~i_req | ~last_d_q);
    assign req_addr   = (pick_d ? d_dfp_addr : i_dfp_addr) & LINE_MASK;
    // Beats tagged with another line's address are not ours and are dropped.
    assign beat_match = bmem_rvalid && (bmem_raddr == addr_q);

    // Transaction FSM: arbitration, command issue, beat gather/scatter and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            last_d_q   <= 1'b1;
            grant_d_q  <= 1'b0;
            addr_q     <= '0;
            line_buf_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        grant_d_q <= pick_d;
                        addr_q    <= req_addr;
                        beat_q    <= '0;
                        if (pick_d && d_dfp_write) begin
                            line_buf_q <= d_dfp_wdata;
                            state_q    <= StWrBurst;
                        end else begin
                            state_q    <= StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    if (bmem_ready) begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (beat_match) begin
                        line_buf_q[BEAT_W*beat_q +: BEAT_W] <= bmem_rdata;
                        beat_q <= beat_q + BEAT_CW'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_q <= StResp;
                        end
                    end
                end
                StWrBurst: begin
                    if (bmem_ready) begin
                        beat_q <= beat_q + BEAT_CW'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    last_d_q <= grant_d_q;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decoded from state and the line buffer only.
    always_comb begin
        bmem_addr   = addr_q;
        bmem_read   = (state_q == StRdReq);
        bmem_write  = (state_q == StWrBurst);
        bmem_wdata  = line_buf_q[BEAT_W*beat_q +: BEAT_W];
        i_dfp_resp  = (state_q == StResp) && !grant_d_q;
        d_dfp_resp  = (state_q == StResp) && grant_d_q;
        i_dfp_rdata = line_buf_q;
        d_dfp_rdata = line_buf_q;
    end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: a table of single transactions plus
// hand-written sequences for contention and mid-transaction reset.
module tb_bmem_line_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int tests = 0;
    int fails = 0;

    bmem_line_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           side_d;     // 1 = D-cache request
        bit           wr;         // writeback
        bit           both;       // D raises read together with write
        logic [31:0]  addr;
        logic [31:0]  exp_addr;   // line-aligned address expected on bmem
        logic [255:0] data;       // line written, or beats returned by memory
        int           stall_n;    // ready-low cycles
        int           stall_beat; // write beat index the stall hits
        bit           stray;      // inject one mismatched read beat
        int           stray_beat;
        int           exp_resp;   // resp cycle, request seen in IDLE at cycle 0
        int           exp_rd;     // cycles with bmem_read high
        int           exp_wr;     // cycles with bmem_write high
    } txn_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input txn_t t);
        i_dfp_read  = !t.side_d;
        d_dfp_read  = t.side_d && (!t.wr || t.both);
        d_dfp_write = t.side_d && t.wr;
        if (t.side_d) d_dfp_addr = t.addr;
        else          i_dfp_addr = t.addr;
        if (t.wr) d_dfp_wdata = t.data;
    endtask

    // Acts as the memory for one transaction, starting at its IDLE cycle (a negedge).
    // Returns at the negedge of the following IDLE cycle.
    task automatic serve(input txn_t t, input bit drop);
        int cyc = 0;
        int rbeat = 0;
        int wbeat = 0;
        int acc = -1;
        int stall_left = t.stall_n;
        int resp_cyc = -1;
        int rd_n = 0;
        int wr_n = 0;
        bit stray_done = 0;
        bit rd;
        bit wr;
        while (cyc < 60 && resp_cyc < 0) begin
            rd = bmem_read;
            wr = bmem_write;
            if (rd) begin
                rd_n++;
                chk("rd_addr", 256'(bmem_addr), 256'(t.exp_addr));
            end
            if (wr) begin
                wr_n++;
                chk("wr_addr", 256'(bmem_addr), 256'(t.exp_addr));
                if (wbeat < 4) chk("wr_data", 256'(bmem_wdata), 256'(t.data[64*wbeat +: 64]));
                else           chk("wr_extra_beat", 256'(wbeat), 256'(3));
            end
            if (i_dfp_resp || d_dfp_resp) begin
                resp_cyc = cyc;
                chk("resp_side", 256'({i_dfp_resp, d_dfp_resp}), t.side_d ? 256'(1) : 256'(2));
                if (!t.wr) chk("rdata", t.side_d ? d_dfp_rdata : i_dfp_rdata, t.data);
                if (drop) begin
                    if (t.side_d) begin
                        d_dfp_read  = 1'b0;
                        d_dfp_write = 1'b0;
                    end else begin
                        i_dfp_read = 1'b0;
                    end
                end
            end
            bmem_ready = 1'b1;
            if (stall_left > 0 && (rd || (wr && wbeat == t.stall_beat))) begin
                bmem_ready = 1'b0;
                stall_left--;
            end
            bmem_rvalid = 1'b0;
            bmem_raddr  = '0;
            bmem_rdata  = '0;
            if (acc >= 0 && cyc > acc && rbeat < 4) begin
                bmem_rvalid = 1'b1;
                if (t.stray && !stray_done && rbeat == t.stray_beat) begin
                    bmem_raddr = t.exp_addr ^ 32'h20;
                    bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    stray_done = 1;
                end else begin
                    bmem_raddr = t.exp_addr;
                    bmem_rdata = t.data[64*rbeat +: 64];
                    rbeat++;
                end
            end
            if (rd && bmem_ready) acc = cyc;
            if (wr && bmem_ready) wbeat++;
            if (resp_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_ready  = 1'b1;
        chk("resp_cycle", 256'(resp_cyc), 256'(t.exp_resp));
        chk("rd_cycles", 256'(rd_n), 256'(t.exp_rd));
        chk("wr_cycles", 256'(wr_n), 256'(t.exp_wr));
        @(negedge clk);
        chk("resp_one_cycle", 256'({i_dfp_resp, d_dfp_resp}), 256'(0));
    endtask

    task automatic run_txn(input txn_t t);
        drive_req(t);
        serve(t, 1'b1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rd"},    256'(bmem_read), 256'(0));
        chk({name, "_wr"},    256'(bmem_write), 256'(0));
        chk({name, "_resp"},  256'({i_dfp_resp, d_dfp_resp}), 256'(0));
        chk({name, "_addr"},  256'(bmem_addr), 256'(0));
        chk({name, "_wdata"}, 256'(bmem_wdata), 256'(0));
        chk({name, "_irdata"}, i_dfp_rdata, 256'(0));
        chk({name, "_drdata"}, d_dfp_rdata, 256'(0));
    endtask

    txn_t tbl[6];
    txn_t ti;
    txn_t td;
    txn_t tr;
    logic [255:0] d0;
    logic [255:0] d1;
    logic [255:0] d2;

    initial begin
        d0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        d1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'hA5A5_5A5A_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};
        d2 = {64'hCAFE_F00D_0000_0004, 64'hCAFE_F00D_0000_0003,
              64'hCAFE_F00D_0000_0002, 64'hCAFE_F00D_0000_0001};
        //          side wr both addr          exp_addr      data stl sb  str sbt resp rd wr
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h1000_0024, 32'h1000_0020, d0, 0, 0, 1'b0, 0, 6, 1, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h2000_0040, 32'h2000_0040, d0, 0, 0, 1'b0, 0, 5, 0, 4};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h2000_005C, 32'h2000_0040, d1, 2, 1, 1'b0, 0, 7, 0, 6};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h3000_0008, 32'h3000_0000, d2, 0, 0, 1'b1, 2, 7, 1, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h4000_007F, 32'h4000_0060, d1, 1, 0, 1'b0, 0, 7, 2, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h5000_0010, 32'h5000_0000, d2, 0, 0, 1'b0, 0, 5, 0, 4};

        rst         = 1'b0;
        i_dfp_addr  = '0;
        i_dfp_read  = 1'b0;
        d_dfp_addr  = '0;
        d_dfp_read  = 1'b0;
        d_dfp_write = 1'b0;
        d_dfp_wdata = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;

        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i]);
        end

        // Contention right after a fresh reset: I wins first, then grants alternate.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ti = '{1'b0, 1'b0, 1'b0, 32'h0A00_0104, 32'h0A00_0100, d1, 0, 0, 1'b0, 0, 6, 1, 0};
        td = '{1'b1, 1'b0, 1'b0, 32'h0B00_0208, 32'h0B00_0200, d2, 0, 0, 1'b0, 0, 6, 1, 0};
        i_dfp_addr = ti.addr;
        i_dfp_read = 1'b1;
        d_dfp_addr = td.addr;
        d_dfp_read = 1'b1;
        serve(ti, 1'b0);
        serve(td, 1'b0);
        serve(ti, 1'b1);
        serve(td, 1'b1);

        // Reset in the middle of a read after two beats.
        tr = '{1'b0, 1'b0, 1'b0, 32'h6000_0044, 32'h6000_0040, d0, 0, 0, 1'b0, 0, 6, 1, 0};
        i_dfp_addr = tr.addr;
        i_dfp_read = 1'b1;
        @(negedge clk);
        chk("mid_rd_cmd", 256'(bmem_read), 256'(1));
        @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_raddr  = tr.exp_addr;
        bmem_rdata  = 64'h1111_1111_1111_1111;
        @(negedge clk);
        bmem_rdata  = 64'h2222_2222_2222_2222;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        #2 rst = 1'b0;
        #1 chk_all_zero("async_reset");
        i_dfp_read  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'h3333_3333_3333_3333;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("late_beat_resp", 256'({i_dfp_resp, d_dfp_resp}), 256'(0));
            chk("late_beat_rdata", i_dfp_rdata, 256'(0));
            chk("late_beat_rd", 256'(bmem_read), 256'(0));
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        @(negedge clk);
        run_txn(tr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
